neuron_mac_stream: RTL and testbench

//  Parametrised streaming neuron: signed dot product of a LANES-wide input/weight vector slice per

---
 rtl/neuron_mac_stream.sv | 170 +++++++++++++++++
 tb/tb_neuron_mac_stream.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_stream.sv
// Streaming neuron: signed LANES-wide dot product per beat, accumulated with saturation until in_last.
// Optional `NEURON_RELU_EN clamps negative results to zero on output (linear neuron when undefined).
module neuron_mac_stream #(
    parameter int LANES  = 4,
    parameter int DATA_W = 5,
    parameter int WGT_W  = 5,
    parameter int ACC_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [LANES*WGT_W-1:0]    in_wgt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [ACC_W-1:0]   out_data,
    output logic                      out_ovf
);

    localparam int PROD_W = DATA_W + WGT_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
    localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    localparam logic signed [EXT_W-1:0] ACC_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                      state;
    logic                        accept;
    logic                        leave_done;

    logic                        s1_valid;
    logic                        s1_last;
    logic [LANES*DATA_W-1:0]     s1_data;
    logic [LANES*WGT_W-1:0]      s1_wgt;

    logic signed [DATA_W-1:0]    lane_d    [LANES];
    logic signed [WGT_W-1:0]     lane_w    [LANES];
    logic signed [PROD_W-1:0]    lane_prod [LANES];

    logic signed [SUM_W-1:0]     partial;
    logic signed [EXT_W-1:0]     ext_sum;
    logic signed [ACC_W-1:0]     sat_val;
    logic                        sat_hit;

    logic signed [ACC_W-1:0]     acc;
    logic                        ovf;
    logic                        s2_done;
    logic signed [ACC_W-1:0]     result_val;

    assign accept     = in_valid && in_ready;
    assign leave_done = (state == DONE) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            s1_wgt   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= in_last;
                s1_data <= in_data;
                s1_wgt  <= in_wgt;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_d[i]    = s1_data[i*DATA_W +: DATA_W];
        assign lane_w[i]    = s1_wgt[i*WGT_W +: WGT_W];
        assign lane_prod[i] = lane_d[i] * lane_w[i];
    end

    // Full-precision sum of the beat, widened so the add into acc cannot wrap before the clamp.
    always_comb begin
        partial = '0;
        for (int i = 0; i < LANES; i++) begin
            partial = partial + SUM_W'(lane_prod[i]);
        end
        ext_sum = EXT_W'(acc) + EXT_W'(partial);
        sat_hit = 1'b0;
        sat_val = ext_sum[ACC_W-1:0];
        if (ext_sum > ACC_MAX) begin
            sat_val = {1'b0, {(ACC_W-1){1'b1}}};
            sat_hit = 1'b1;
        end else if (ext_sum < ACC_MIN) begin
            sat_val = {1'b1, {(ACC_W-1){1'b0}}};
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            ovf     <= 1'b0;
            s2_done <= 1'b0;
        end else begin
            s2_done <= s1_valid && s1_last;
            if (leave_done) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (s1_valid) begin
                acc <= sat_val;
                ovf <= ovf | sat_hit;
            end
        end
    end

`ifdef NEURON_RELU_EN
    assign result_val = acc[ACC_W-1] ? '0 : acc;
`else
    assign result_val = acc;
`endif

    // in_ready is registered so it stays low through reset and the first cycle after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= in_last ? DRAIN : ACCUM;
                        in_ready <= !in_last;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept && in_last) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                DRAIN: begin
                    in_ready <= 1'b0;
                    if (s2_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= result_val;
                        out_ovf   <= ovf;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_stream.sv
// Self-checking bench for neuron_mac_stream: directed cases plus random vectors against a per-beat clamp model.
module tb_neuron_mac_stream;

    localparam int LANES  = 4;
    localparam int DATA_W = 5;
    localparam int WGT_W  = 5;
    localparam int ACC_W  = 12;
    localparam int MAXB   = 8;
    localparam int ACC_HI = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_LO = -(1 << (ACC_W - 1));

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic                      in_last = 1'b0;
    logic [LANES*DATA_W-1:0]   in_data = '0;
    logic [LANES*WGT_W-1:0]    in_wgt = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic signed [ACC_W-1:0]   out_data;
    logic                      out_ovf;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int acceptCycle = 0;
    int bIn [MAXB][LANES];
    int bW  [MAXB][LANES];
    int expData;
    int expOvf;

    neuron_mac_stream #(
        .LANES (LANES),
        .DATA_W(DATA_W),
        .WGT_W (WGT_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .in_data  (in_data),
        .in_wgt   (in_wgt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: each beat's dot product is added in full, then the running sum is clamped.
    function automatic void modelVector(input int n);
        int acc;
        int s;
        acc = 0;
        expOvf = 0;
        for (int b = 0; b < n; b++) begin
            s = 0;
            for (int l = 0; l < LANES; l++) s += bIn[b][l] * bW[b][l];
            acc += s;
            if (acc > ACC_HI) begin acc = ACC_HI; expOvf = 1; end
            if (acc < ACC_LO) begin acc = ACC_LO; expOvf = 1; end
        end
`ifdef NEURON_RELU_EN
        expData = (acc < 0) ? 0 : acc;
`else
        expData = acc;
`endif
    endfunction

    task automatic fillConst(input int b, input int a, input int w);
        for (int l = 0; l < LANES; l++) begin
            bIn[b][l] = a;
            bW[b][l]  = w;
        end
    endtask

    task automatic fillRandom(input int n);
        for (int b = 0; b < n; b++) begin
            for (int l = 0; l < LANES; l++) begin
                bIn[b][l] = int'($urandom_range(0, 31)) - 16;
                bW[b][l]  = int'($urandom_range(0, 31)) - 16;
            end
        end
    endtask

    task automatic applyStimulus(input int n, input bit gaps, input bit endWithLast);
        int  budget;
        bit  rdy;
        for (int b = 0; b < n; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_last  = 1'($urandom_range(0, 1));
                    in_data  = (LANES*DATA_W)'($urandom);
                    in_wgt   = (LANES*WGT_W)'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_last  = endWithLast && (b == n - 1);
            for (int l = 0; l < LANES; l++) begin
                in_data[l*DATA_W +: DATA_W] = DATA_W'(bIn[b][l]);
                in_wgt[l*WGT_W +: WGT_W]    = WGT_W'(bW[b][l]);
            end
            budget = 0;
            do begin
                @(negedge clk);
                rdy = in_ready;
                @(posedge clk); #1;
                budget++;
            end while (!rdy && budget < 50);
            if (!rdy) check("accept_timeout", 0, 1);
            acceptCycle = cycleCnt;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int expD, input int expO, input int hold);
        int waitN;
        logic signed [ACC_W-1:0] held;
        waitN = 0;
        @(negedge clk);
        while (!out_valid && waitN < 20) begin
            @(negedge clk);
            waitN++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        check({tag, "_latency"}, cycleCnt - acceptCycle, 2);
        check({tag, "_data"}, out_data, expD);
        check({tag, "_ovf"}, out_ovf, expO);
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_data"}, out_data, held);
            check({tag, "_hold_inready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_consumed"}, out_valid, 0);
        check({tag, "_ready_again"}, in_ready, 1);
    endtask

    initial begin
        int n;
        $display("[TB] start");
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inready", in_ready, 0);
        check("rst_outvalid", out_valid, 0);
        check("rst_outdata", out_data, 0);
        check("rst_ovf", out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        fillConst(0, 1, 2);
        applyStimulus(1, 0, 1);
        checkOutput("one_beat", 8, 0, 0);

        fillConst(0, 3, -1);
        fillConst(1, -2, 5);
        fillConst(2, 1, 1);
        applyStimulus(3, 1, 1);
        checkOutput("gaps", -48, 0, 0);

        for (int b = 0; b < 3; b++) fillConst(b, -16, -16);
        applyStimulus(3, 0, 1);
        checkOutput("sat", 2047, 1, 0);
        fillConst(0, 1, 1);
        applyStimulus(1, 0, 1);
        checkOutput("after_sat", 4, 0, 0);

        fillRandom(3);
        modelVector(3);
        applyStimulus(3, 1, 1);
        checkOutput("backpressure", expData, expOvf, 5);

        fillRandom(2);
        applyStimulus(2, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_inready", in_ready, 0);
        check("midrst_outvalid", out_valid, 0);
        check("midrst_outdata", out_data, 0);
        check("midrst_ovf", out_ovf, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fillConst(0, 1, 1);
        applyStimulus(1, 0, 1);
        checkOutput("after_rst", 4, 0, 0);

        fillConst(0, 1, -3);
`ifdef NEURON_RELU_EN
        applyStimulus(1, 0, 1);
        checkOutput("relu_neg", 0, 0, 0);
`else
        applyStimulus(1, 0, 1);
        checkOutput("linear_neg", -12, 0, 0);
`endif

        for (int v = 0; v < 25; v++) begin
            n = int'($urandom_range(1, 6));
            fillRandom(n);
            modelVector(n);
            applyStimulus(n, 1, 1);
            checkOutput("rand", expData, expOvf, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
